// File: rtl/urv_fetch.sv
// uRV instruction fetch stage: sequential instruction-memory reads, in-flight tracking,
// a small {ir, pc} buffer towards decode, and redirect handling that drops stale responses.
module urv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] im_addr_o,
    output logic        im_rd_o,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,
    input  logic        f_stall_i,
    input  logic        x_branch_take_i,
    input  logic [31:0] x_branch_target_i,
    output logic        f_valid_o,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_r;
    logic [31:0]   resp_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [31:0]   ir_mem_r [FIFO_DEPTH];
    logic [31:0]   pc_mem_r [FIFO_DEPTH];

    logic          valid_s;
    logic          pop_s;
    logic          resp_s;
    logic          push_s;
    logic          issue_s;
    logic [CW:0]   inflight_s;

    // Handshake decode: pop, response acceptance, push and issue decisions for this cycle.
    always_comb begin
        valid_s    = 1'b0;
        pop_s      = 1'b0;
        resp_s     = 1'b0;
        push_s     = 1'b0;
        issue_s    = 1'b0;
        inflight_s = {(CW + 1){1'b0}};
        if (rst_i) begin
            valid_s = 1'b0;
        end else begin
            valid_s = (count_r != {CW{1'b0}});
        end
        pop_s  = valid_s && !f_stall_i && !x_branch_take_i;
        resp_s = im_valid_i && (outstanding_r != {CW{1'b0}});
        push_s = resp_s && (drop_r == {CW{1'b0}}) && !x_branch_take_i;
        // A slot freed by this cycle's pop may be refilled by this cycle's issue.
        inflight_s = {1'b0, outstanding_r} + {1'b0, count_r} - {{CW{1'b0}}, pop_s};
        issue_s    = !rst_i && !x_branch_take_i && (inflight_s < DEPTH_L);
    end

    assign im_rd_o   = issue_s;
    assign im_addr_o = pc_r;
    assign f_valid_o = valid_s;
    assign f_ir_o    = ir_mem_r[rd_ptr_r];
    assign f_pc_o    = pc_mem_r[rd_ptr_r];

    // Fetch state: PCs, in-flight and drop counters, buffer pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r          <= RESET_VECTOR;
            resp_pc_r     <= RESET_VECTOR;
            outstanding_r <= {CW{1'b0}};
            drop_r        <= {CW{1'b0}};
            count_r       <= {CW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
        end else if (x_branch_take_i) begin
            pc_r          <= x_branch_target_i;
            resp_pc_r     <= x_branch_target_i;
            outstanding_r <= outstanding_r - CW'(resp_s);
            drop_r        <= outstanding_r - CW'(resp_s);
            count_r       <= {CW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
        end else begin
            if (issue_s) begin
                pc_r <= pc_r + 32'd4;
            end
            outstanding_r <= outstanding_r + CW'(issue_s) - CW'(resp_s);
            if (resp_s && (drop_r != {CW{1'b0}})) begin
                drop_r <= drop_r - CW'(1'b1);
            end
            if (push_s) begin
                wr_ptr_r  <= wr_ptr_r + PW'(1'b1);
                resp_pc_r <= resp_pc_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            ir_mem_r[wr_ptr_r] <= im_data_i;
            pc_mem_r[wr_ptr_r] <= resp_pc_r;
        end
    end

endmodule

// File: tb/tb_urv_fetch.sv
// Bench for urv_fetch: in-order memory model with programmable latency, and a
// transaction-level reference (request/buffer queues with redirect epochs).
module tb_urv_fetch;

    localparam int DEPTH = 2;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, stall, br;
    logic [31:0] target;
    logic [31:0] im_addr, im_data, f_ir, f_pc;
    logic        im_rd, im_valid, f_valid;
    logic [31:0] im_addr_w, im_data_w, f_ir_w, f_pc_w;
    logic        im_rd_w, im_valid_w, f_valid_w;

    req_t        memq[$];
    ent_t        bufq[$];
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat = 1;
    logic [31:0] exp_pc = 32'h0000_0000;
    logic        wrd_prev = 1'b0;
    logic [31:0] waddr_prev = 32'h0000_0000;
    int          wcyc = -1;
    int          ntests = 0;
    int          nfail = 0;

    logic [31:0] w_addr_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    always #5 clk = ~clk;

    urv_fetch #(.RESET_VECTOR(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .im_addr_o(im_addr), .im_rd_o(im_rd),
        .im_data_i(im_data), .im_valid_i(im_valid), .f_stall_i(stall),
        .x_branch_take_i(br), .x_branch_target_i(target),
        .f_valid_o(f_valid), .f_ir_o(f_ir), .f_pc_o(f_pc)
    );

    urv_fetch #(.RESET_VECTOR(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk_i(clk), .rst_i(rst), .im_addr_o(im_addr_w), .im_rd_o(im_rd_w),
        .im_data_i(im_data_w), .im_valid_i(im_valid_w), .f_stall_i(1'b0),
        .x_branch_take_i(1'b0), .x_branch_target_i(32'h0000_0000),
        .f_valid_o(f_valid_w), .f_ir_o(f_ir_w), .f_pc_o(f_pc_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are checked, model advances.
    task automatic step();
        req_t r;
        logic resp;
        logic exp_valid, exp_pop, exp_rd;
        int   occ, d;
        resp = 1'b0;
        r = '{addr: 32'h0000_0000, epoch: 0, due: 0};
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            resp     = 1'b1;
            r        = memq[0];
            im_valid = 1'b1;
            im_data  = r.addr ^ KEY;
        end else begin
            im_valid = 1'b0;
            im_data  = $urandom;
        end
        im_valid_w = wrd_prev;
        im_data_w  = waddr_prev ^ KEY;
        #1;
        exp_valid = !rst && (bufq.size() > 0);
        check("f_valid", {31'd0, f_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            check("f_pc", f_pc, bufq[0].pc);
            check("f_ir", f_ir, bufq[0].ir);
        end
        exp_pop = exp_valid && !stall && !br;
        occ     = memq.size() + bufq.size() - (exp_pop ? 1 : 0);
        exp_rd  = !rst && !br && (occ < DEPTH);
        check("im_rd", {31'd0, im_rd}, {31'd0, exp_rd});
        if (exp_rd) check("im_addr", im_addr, exp_pc);
        if (wcyc >= 0 && wcyc < 5) begin
            if (wcyc < 3) begin
                check("wrap_rd", {31'd0, im_rd_w}, 32'd1);
                check("wrap_addr", im_addr_w, w_addr_exp[wcyc]);
            end
            if (wcyc >= 2) begin
                check("wrap_valid", {31'd0, f_valid_w}, 32'd1);
                check("wrap_pc", f_pc_w, w_addr_exp[wcyc - 2]);
                check("wrap_ir", f_ir_w, w_addr_exp[wcyc - 2] ^ KEY);
            end
            wcyc++;
        end
        if (resp) memq.delete(0);
        if (rst) begin
            memq.delete();
            bufq.delete();
            epoch++;
            exp_pc = 32'h0000_0000;
        end else if (br) begin
            bufq.delete();
            epoch++;
            exp_pc = target;
        end else begin
            if (resp && r.epoch == epoch) bufq.push_back('{ir: r.addr ^ KEY, pc: r.addr});
            if (exp_pop) bufq.delete(0);
            if (exp_rd) exp_pc = exp_pc + 32'd4;
        end
        if (im_rd && !rst) begin
            d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            memq.push_back('{addr: im_addr, epoch: epoch, due: d});
        end
        wrd_prev   = im_rd_w;
        waddr_prev = im_addr_w;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] t;
        rst = 1'b1; stall = 1'b0; br = 1'b0; target = 32'h0000_0000;
        im_valid = 1'b0; im_data = 32'h0000_0000;
        im_valid_w = 1'b0; im_data_w = 32'h0000_0000;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        wcyc = 0;

        // Streaming from reset with 1-cycle memory.
        step();
        step();
        check("first_valid", {31'd0, f_valid}, 32'd1);
        check("first_pc", f_pc, 32'h0000_0000);
        check("first_ir", f_ir, 32'hA5A5_A5A5);
        repeat (10) step();

        // Decode stall for five cycles, then release.
        stall = 1'b1;
        repeat (5) step();
        stall = 1'b0;
        repeat (8) step();

        // Three-cycle memory latency.
        lat = 3;
        repeat (24) step();

        // Redirect with two requests in flight (latency 2).
        lat = 2;
        for (int i = 0; i < 20 && memq.size() != 2; i++) step();
        check("two_outstanding", 32'(memq.size()), 32'd2);
        br = 1'b1; target = 32'h0000_0100;
        step();
        br = 1'b0;
        for (int i = 0; i < 20 && !f_valid; i++) step();
        check("redir_valid", {31'd0, f_valid}, 32'd1);
        check("redir_pc", f_pc, 32'h0000_0100);
        repeat (6) step();

        // Redirect coinciding with a pop and an arriving response.
        lat = 1;
        repeat (4) step();
        for (int i = 0; i < 20 && !(f_valid && memq.size() > 0 && memq[0].due <= cyc); i++) step();
        check("pop_resp_ready", {31'd0, f_valid}, 32'd1);
        br = 1'b1; target = 32'h0000_0200;
        step();
        br = 1'b0;
        #1;
        check("flush_empty", {31'd0, f_valid}, 32'd0);
        check("target_issue", {31'd0, im_rd}, 32'd1);
        check("target_addr", im_addr, 32'h0000_0200);
        repeat (6) step();

        // Back-to-back redirects: the last target wins.
        br = 1'b1; target = 32'h0000_0300;
        step();
        target = 32'h0000_0400;
        step();
        br = 1'b0;
        for (int i = 0; i < 20 && !f_valid; i++) step();
        check("b2b_pc", f_pc, 32'h0000_0400);
        repeat (4) step();

        // Randomized traffic with stalls, redirects, latency changes and resets.
        for (int i = 0; i < 500; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 3);
            stall = ($urandom_range(0, 99) < 30);
            br    = ($urandom_range(0, 99) < 6);
            t     = $urandom;
            target = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : (t & 32'hFFFF_FFFC);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; stall = 1'b0; br = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/urv_fetch.md
Name: urv_fetch

Overview:
- Instruction fetch stage of the uRV pipeline; feeds decode, which in turn feeds the execute stage.
- Issues sequential instruction-memory reads and tracks in-flight requests.
- Buffers returned instructions with their PCs in a small FIFO, so a decode stall never loses data.
- Redirects on a taken branch or exception from execute, discarding stale in-flight responses.

Parameters:
- RESET_VECTOR, 32'h00000000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, instruction buffer entries and max (outstanding + buffered) requests; power of 2, >=2.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- im_addr_o  out  32  instruction memory read address, word aligned.
- im_rd_o  out  1  read request; the memory accepts every asserted cycle (no backpressure).
- im_data_i  in  32  read data, valid when im_valid_i=1.
- im_valid_i  in  1  response strobe; responses come in order, latency >=1 cycle.
- f_stall_i  in  1  decode cannot accept the head instruction this cycle.
- x_branch_take_i  in  1  registered redirect from execute (branch, jump, exception, eret).
- x_branch_target_i  in  32  redirect PC, sampled when x_branch_take_i=1.
- f_valid_o  out  1  FIFO head holds a valid instruction.
- f_ir_o  out  32  head instruction word.
- f_pc_o  out  32  head instruction PC.

Behaviour:
- State:
  - pc: next request address.
  - resp_pc: PC of the oldest outstanding request.
  - outstanding: issued but not yet returned, width clog2(FIFO_DEPTH+1).
  - drop: outstanding responses still to be discarded.
  - FIFO: {ir, pc} entries with wr/rd pointers and count.
- Reset, while rst_i=1:
  - pc=resp_pc=RESET_VECTOR.
  - outstanding=drop=count=0.
  - im_rd_o=0, f_valid_o=0; f_ir_o/f_pc_o don't-care.
- Pop: pop = f_valid_o && !f_stall_i && !x_branch_take_i. The head advances on that edge.
- Issue:
  - im_rd_o = !rst_i && !x_branch_take_i && (outstanding + count - pop) < FIFO_DEPTH.
  - The stall-to-im_rd_o combinational path is intended; it gives full throughput with 1-cycle memory.
  - im_addr_o = pc at all times. On issue: pc <= pc+4 (mod 2^32, wraps 32'hFFFFFFFC -> 0), outstanding++.
- Response, when im_valid_i=1 and outstanding>0:
  - outstanding--.
  - If drop>0: drop--, data discarded.
  - Otherwise: push {im_data_i, resp_pc}, then resp_pc <= resp_pc+4.
  - Issue and response in the same cycle leave outstanding unchanged.
- im_valid_i with outstanding==0: ignored (protocol violation, no state change).
- FIFO never overflows: the issue rule guarantees count+outstanding <= FIFO_DEPTH.
- Redirect (x_branch_take_i=1) has priority over pop, push and issue:
  - FIFO flushed (count=0, pointers reset).
  - pc <= target, resp_pc <= target.
  - drop <= outstanding - (im_valid_i && outstanding>0 ? 1 : 0). An arriving response is counted as discarded.
  - No issue in the redirect cycle. The first fetch of the target is at T+1.
  - This applies regardless of f_stall_i.
- Back-to-back redirects: each recomputes drop from the current outstanding; the last target wins.
- Latency with 1-cycle memory:
  - Request at cycle N -> response at N+1 -> f_valid_o at N+2.
  - Redirect at T -> target on f_valid_o at T+3.
- The FIFO head is held stable while f_valid_o=1 and f_stall_i=1.
- Reset mid-operation: all state cleared next edge. Responses arriving after reset with outstanding=0 are ignored.
- Target alignment: target[1:0] is passed through unchecked; the misalignment exception is handled by execute.

Test Plan:
- Reset release, 1-cycle memory returning data=addr^32'hA5A5A5A5, f_stall_i=0:
  - im_addr_o is 0,4,8,... at cycles 0,1,2.
  - f_valid_o=1 from cycle 2 with f_pc_o=0, f_ir_o=32'hA5A5A5A5.
  - Then one instruction per cycle.
- f_stall_i=1 for 5 cycles during streaming:
  - Head held stable; im_rd_o drops once outstanding+count=2.
  - After release, PCs continue with no gap or duplicate (0,4,8,12,... strictly sequential).
- Memory latency 3 cycles, FIFO_DEPTH=2: at most 2 outstanding requests; all responses delivered in order with correct PCs.
- Redirect to 32'h100 with 2 outstanding (latency 2):
  - Both stale responses discarded.
  - First f_valid_o after the redirect shows f_pc_o=32'h100.
  - Nothing from the old stream ever reaches the output.
- Redirect in the same cycle as pop and response:
  - FIFO empty next cycle; the response is dropped.
  - The next issue is to the target at T+1.
- Wrap: RESET_VECTOR=32'hFFFFFFF8 -> im_addr_o sequence FFFFFFF8, FFFFFFFC, 00000000; matching f_pc_o values on the output.
